// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and limits for the clock-setting controller.
// Also holds the 24h-to-12h display mapping used by the top.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SET_HOURS = 2'd1,
    ST_SET_MINS  = 2'd2,
    ST_SET_SECS  = 2'd3
  } set_state_t;

  localparam int unsigned HOURS_MAX = 23;
  localparam int unsigned MINS_MAX  = 59;
  localparam int unsigned SECS_MAX  = 59;

  // In 12h mode, hours 0 and 12 both read as 12.
  function automatic logic [7:0] disp_hour(input logic [7:0] hour, input logic h24);
    logic [7:0] r;
    if (h24) r = hour;
    else if (hour == 8'd0 || hour == 8'd12) r = 8'd12;
    else if (hour > 8'd12) r = hour - 8'd12;
    else r = hour;
    return r;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_wrap_counter.sv
// Modulo 0..MAX up/down counter with synchronous clear, one per time field.
// Clear has priority over increment, increment over decrement.
module wrap_counter #(
  parameter int unsigned MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_clr,
  output logic [7:0] o_value
);

  localparam logic [7:0] L_MAX = 8'(MAX);

  logic [7:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_value <= 8'd0;
    else if (i_clr) r_value <= 8'd0;
    else if (i_inc) r_value <= (r_value == L_MAX) ? 8'd0 : r_value + 8'd1;
    else if (i_dec) r_value <= (r_value == 8'd0) ? L_MAX : r_value - 8'd1;
    else r_value <= r_value;
  end

  assign o_value = r_value;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day keeper with a set/up/down editing FSM and idle timeout.
// Optional auto-repeat of held up/down buttons: define SET_AUTOREPEAT_EN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int H24           = 1,
  parameter int TIMEOUT_TICKS = 10,
  parameter int RPT_DELAY     = 50_000_000,
  parameter int RPT_PERIOD    = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] hours,
  output logic [7:0] mins,
  output logic [7:0] secs,
  output logic       pm,
  output logic [1:0] edit_field
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  set_state_t      r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic            r_set_q, r_up_q, r_dn_q, r_arm;
  logic            w_set_e, w_up_e, w_dn_e, w_any_e, w_in_set;
  logic            w_syn_up, w_syn_dn, w_up_act, w_dn_act;
  logic            w_tick_idle, w_sec_wrap, w_min_wrap;
  logic [7:0]      w_hour, w_min, w_sec;

  // r_arm masks edges on the first cycle after reset, so levels held through reset are not edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_set_q <= 1'b0;
      r_up_q  <= 1'b0;
      r_dn_q  <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_set_q <= btn_set;
      r_up_q  <= btn_up;
      r_dn_q  <= btn_down;
      r_arm   <= 1'b1;
    end
  end

  assign w_set_e  = r_arm & btn_set & ~r_set_q;
  assign w_up_e   = r_arm & btn_up & ~r_up_q;
  assign w_dn_e   = r_arm & btn_down & ~r_dn_q;
  assign w_any_e  = w_set_e | w_up_e | w_dn_e;
  assign w_in_set = (r_state != ST_IDLE);

`ifdef SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first, w_held, w_rpt_fire;

  assign w_held     = ((r_state == ST_SET_HOURS) || (r_state == ST_SET_MINS)) && (btn_up ^ btn_down);
  assign w_rpt_fire = w_held & ~w_any_e &
                      (r_rpt_cnt == (r_rpt_first ? RPT_W'(RPT_DELAY - 1) : RPT_W'(RPT_PERIOD - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (!w_held || w_any_e) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_rpt_fire) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b0;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + RPT_W'(1);
      r_rpt_first <= r_rpt_first;
    end
  end

  assign w_syn_up = w_rpt_fire & btn_up;
  assign w_syn_dn = w_rpt_fire & btn_down;
`else
  assign w_syn_up = 1'b0;
  assign w_syn_dn = 1'b0;
`endif

  // A set edge wins; simultaneous up+down cancel out.
  assign w_up_act    = w_in_set & ~w_set_e & ((w_up_e & ~w_dn_e) | w_syn_up);
  assign w_dn_act    = w_in_set & ~w_set_e & ((w_dn_e & ~w_up_e) | w_syn_dn);
  assign w_tick_idle = tick_1hz & (r_state == ST_IDLE);
  assign w_sec_wrap  = (w_sec == 8'(SECS_MAX));
  assign w_min_wrap  = (w_min == 8'(MINS_MAX));

  wrap_counter #(.MAX(HOURS_MAX)) u_hour (
    .clk(clk), .reset(reset),
    .i_inc(((r_state == ST_SET_HOURS) & w_up_act) | (w_tick_idle & w_sec_wrap & w_min_wrap)),
    .i_dec((r_state == ST_SET_HOURS) & w_dn_act),
    .i_clr(1'b0),
    .o_value(w_hour)
  );

  wrap_counter #(.MAX(MINS_MAX)) u_min (
    .clk(clk), .reset(reset),
    .i_inc(((r_state == ST_SET_MINS) & w_up_act) | (w_tick_idle & w_sec_wrap)),
    .i_dec((r_state == ST_SET_MINS) & w_dn_act),
    .i_clr(1'b0),
    .o_value(w_min)
  );

  wrap_counter #(.MAX(SECS_MAX)) u_sec (
    .clk(clk), .reset(reset),
    .i_inc(w_tick_idle),
    .i_dec(1'b0),
    .i_clr((r_state == ST_SET_SECS) & (w_up_act | w_dn_act)),
    .o_value(w_sec)
  );

  // Next state and timeout count; only real edges restart the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_cnt;
    if (w_set_e) begin
      w_to_nxt = '0;
      case (r_state)
        ST_IDLE:      w_state_nxt = ST_SET_HOURS;
        ST_SET_HOURS: w_state_nxt = ST_SET_MINS;
        ST_SET_MINS:  w_state_nxt = ST_SET_SECS;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end else if (!w_in_set || w_any_e) begin
      w_to_nxt = '0;
    end else if (tick_1hz) begin
      if (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
        w_state_nxt = ST_IDLE;
        w_to_nxt    = '0;
      end else begin
        w_to_nxt = r_to_cnt + TO_W'(1);
      end
    end else begin
      w_to_nxt = r_to_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_nxt;
    end
  end

  assign hours      = disp_hour(w_hour, H24 != 0);
  assign mins       = w_min;
  assign secs       = w_sec;
  assign pm         = (H24 == 0) && (w_hour >= 8'd12);
  assign edit_field = r_state;

endmodule
